// File: rtl/instr_fetch.sv
// Instruction fetch stage: loadable 2^ADDR_W x 16 instruction memory + PC, feeds decode.
// Latency: 1 cycle from PC to IF_instruction (combinational array read, registered output).
// Backpressure: IF_stall freezes PC and all outputs; a branch still wins over a stall.
//
// Ports:
//   IF_clock, IF_reset          clock, synchronous active-low reset
//   IF_start                    begin fetching at 0 (IDLE/HALT only)
//   IF_stall                    downstream stall (RUN only)
//   IF_branch_taken/_target     PC redirect with one bubble (RUN only)
//   IF_load_en/_addr/_data      memory write port (IDLE/HALT only)
//   IF_instruction/_valid/_pc   registered word to decode, its qualifier and source address
//   IF_halted                   high while stopped on a HALT opcode
module instr_fetch #(
  parameter int          ADDR_W  = 6,
  parameter logic [3:0]  HALT_OP = 4'hF
) (
  input  logic              IF_clock,
  input  logic              IF_reset,
  input  logic              IF_start,
  input  logic              IF_stall,
  input  logic              IF_branch_taken,
  input  logic [ADDR_W-1:0] IF_branch_target,
  input  logic              IF_load_en,
  input  logic [ADDR_W-1:0] IF_load_addr,
  input  logic [15:0]       IF_load_data,
  output logic [15:0]       IF_instruction,
  output logic              IF_valid,
  output logic [ADDR_W-1:0] IF_pc,
  output logic              IF_halted
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    HALT = 2'd2
  } state_t;

  localparam int DEPTH = 2 ** ADDR_W;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       mem [0:DEPTH-1];
  logic [15:0]       word;

  assign word = mem[pc];

  // Memory is never reset; writes are only accepted outside RUN and are
  // suppressed while reset is asserted.
  always_ff @(posedge IF_clock) begin
    if (IF_reset && IF_load_en && (state != RUN)) begin
      mem[IF_load_addr] <= IF_load_data;
    end
  end

  always_ff @(posedge IF_clock) begin
    if (!IF_reset) begin
      state          <= IDLE;
      pc             <= '0;
      IF_instruction <= 16'h0000;
      IF_valid       <= 1'b0;
      IF_pc          <= '0;
      IF_halted      <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (IF_start) begin
            state <= RUN;
            pc    <= '0;
          end
        end

        RUN: begin
          if (IF_branch_taken) begin
            // Redirect inserts exactly one bubble; IF_pc keeps the last real address.
            pc             <= IF_branch_target;
            IF_instruction <= 16'h0000;
            IF_valid       <= 1'b0;
          end else if (IF_stall) begin
            // Hold everything.
          end else if (word[15:12] == HALT_OP) begin
            // The HALT word itself is never presented as valid; pc stays on it.
            state          <= HALT;
            IF_instruction <= 16'h0000;
            IF_valid       <= 1'b0;
            IF_halted      <= 1'b1;
          end else begin
            IF_instruction <= word;
            IF_pc          <= pc;
            IF_valid       <= 1'b1;
            pc             <= pc + ADDR_W'(1);  // wraps silently at the top
          end
        end

        HALT: begin
          if (IF_start) begin
            state     <= RUN;
            pc        <= '0;
            IF_halted <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instr_fetch.sv
module tb_instr_fetch;

  localparam int ADDR_W = 6;

  logic              IF_clock;
  logic              IF_reset;
  logic              IF_start;
  logic              IF_stall;
  logic              IF_branch_taken;
  logic [ADDR_W-1:0] IF_branch_target;
  logic              IF_load_en;
  logic [ADDR_W-1:0] IF_load_addr;
  logic [15:0]       IF_load_data;
  logic [15:0]       IF_instruction;
  logic              IF_valid;
  logic [ADDR_W-1:0] IF_pc;
  logic              IF_halted;

  int checks = 0;
  int errors = 0;

  instr_fetch #(.ADDR_W(ADDR_W), .HALT_OP(4'hF)) dut (
    .IF_clock         (IF_clock),
    .IF_reset         (IF_reset),
    .IF_start         (IF_start),
    .IF_stall         (IF_stall),
    .IF_branch_taken  (IF_branch_taken),
    .IF_branch_target (IF_branch_target),
    .IF_load_en       (IF_load_en),
    .IF_load_addr     (IF_load_addr),
    .IF_load_data     (IF_load_data),
    .IF_instruction   (IF_instruction),
    .IF_valid         (IF_valid),
    .IF_pc            (IF_pc),
    .IF_halted        (IF_halted)
  );

  initial IF_clock = 1'b0;
  always #5 IF_clock = ~IF_clock;

  // One rising edge, then settle 1 time unit before sampling.
  task automatic step();
    @(posedge IF_clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_out(input string tag, input logic vld, input logic [ADDR_W-1:0] pc,
                           input logic [15:0] instr, input logic halted);
    check({tag, ".valid"},  {31'd0, IF_valid},       {31'd0, vld});
    check({tag, ".pc"},     {26'd0, IF_pc},          {26'd0, pc});
    check({tag, ".instr"},  {16'd0, IF_instruction}, {16'd0, instr});
    check({tag, ".halted"}, {31'd0, IF_halted},      {31'd0, halted});
  endtask

  task automatic load(input logic [ADDR_W-1:0] a, input logic [15:0] d, input logic st);
    IF_load_en   = 1'b1;
    IF_load_addr = a;
    IF_load_data = d;
    IF_start     = st;
    step();
    IF_load_en   = 1'b0;
    IF_start     = 1'b0;
  endtask

  initial begin
    IF_reset = 1'b0; IF_start = 1'b0; IF_stall = 1'b0;
    IF_branch_taken = 1'b0; IF_branch_target = '0;
    IF_load_en = 1'b0; IF_load_addr = '0; IF_load_data = 16'h0;

    // Reset held two cycles, then idle with no start.
    step(); step();
    check_out("reset", 1'b0, 6'd0, 16'h0000, 1'b0);
    IF_reset = 1'b1;
    step(); step(); step();
    check_out("idle", 1'b0, 6'd0, 16'h0000, 1'b0);

    // Program load; the last word is written on the same edge as start.
    load(6'd5,  16'h5145, 1'b0);
    load(6'd63, 16'h7001, 1'b0);
    load(6'd0,  16'h1041, 1'b0);
    load(6'd1,  16'h2082, 1'b0);
    load(6'd2,  16'h30C3, 1'b0);
    load(6'd3,  16'hF000, 1'b1);
    check_out("start_edge", 1'b0, 6'd0, 16'h0000, 1'b0);

    // Sequential fetch with a 2-cycle stall at pc 1.
    step();
    check_out("fetch0", 1'b1, 6'd0, 16'h1041, 1'b0);
    step();
    check_out("fetch1", 1'b1, 6'd1, 16'h2082, 1'b0);
    IF_stall = 1'b1;
    step();
    check_out("stall_a", 1'b1, 6'd1, 16'h2082, 1'b0);
    step();
    check_out("stall_b", 1'b1, 6'd1, 16'h2082, 1'b0);
    IF_stall = 1'b0;
    step();
    check_out("fetch2", 1'b1, 6'd2, 16'h30C3, 1'b0);
    step();
    check_out("halt", 1'b0, 6'd2, 16'h0000, 1'b1);

    // Branch and stall are ignored in HALT.
    IF_branch_taken = 1'b1; IF_branch_target = 6'd5; IF_stall = 1'b1;
    step();
    IF_branch_taken = 1'b0; IF_stall = 1'b0;
    step();
    check_out("halt_ign", 1'b0, 6'd2, 16'h0000, 1'b1);

    // Restart from HALT with a same-edge load of address 0.
    load(6'd0, 16'h8002, 1'b1);
    check_out("restart", 1'b0, 6'd2, 16'h0000, 1'b0);
    step();
    check_out("rs_fetch0", 1'b1, 6'd0, 16'h8002, 1'b0);
    step();
    check_out("rs_fetch1", 1'b1, 6'd1, 16'h2082, 1'b0);

    // Branch with simultaneous stall: branch wins, one bubble.
    IF_branch_taken = 1'b1; IF_branch_target = 6'd5; IF_stall = 1'b1;
    step();
    IF_branch_taken = 1'b0; IF_stall = 1'b0;
    check("br_bubble.valid", {31'd0, IF_valid}, 32'd0);
    check("br_bubble.instr", {16'd0, IF_instruction}, 32'd0);
    step();
    check_out("br_target", 1'b1, 6'd5, 16'h5145, 1'b0);

    // Branch to the top address with a RUN-time load that must be dropped.
    IF_branch_taken = 1'b1; IF_branch_target = 6'd63;
    IF_load_en = 1'b1; IF_load_addr = 6'd63; IF_load_data = 16'hDEAD;
    step();
    IF_branch_taken = 1'b0; IF_load_en = 1'b0;
    check("wrap_bubble.valid", {31'd0, IF_valid}, 32'd0);
    step();
    check_out("wrap63", 1'b1, 6'd63, 16'h7001, 1'b0);
    step();
    check_out("wrap0", 1'b1, 6'd0, 16'h8002, 1'b0);
    step();
    check_out("wrap1", 1'b1, 6'd1, 16'h2082, 1'b0);

    // Revisit 63 to confirm the RUN-time load never landed.
    IF_branch_taken = 1'b1; IF_branch_target = 6'd63;
    step();
    IF_branch_taken = 1'b0;
    step();
    check_out("mem_keep", 1'b1, 6'd63, 16'h7001, 1'b0);

    // Reset mid-run while valid is high.
    IF_reset = 1'b0;
    step();
    check_out("mid_reset", 1'b0, 6'd0, 16'h0000, 1'b0);
    IF_reset = 1'b1;
    step(); step();
    check_out("post_reset_idle", 1'b0, 6'd0, 16'h0000, 1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
